// File: rtl/disk_proj_sched_pkg.sv
// Shared types and constants for the disk projection scheduler.
// Holds FSM states, memory sizing and the write-data field layout.
package disk_proj_sched_pkg;

    localparam int NMAX = 64;
    localparam int AW   = 6;
    localparam int CW   = 7;

    localparam int IDX_W   = 6;
    localparam int PHI_W   = 14;
    localparam int R_W     = 12;
    localparam int DATA_W  = 32;
    localparam int IDX_LSB = 26;
    localparam int PHI_LSB = 12;
    localparam int R_LSB   = 0;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN,
        FIN
    } state_e;

    function automatic logic [DATA_W-1:0] pack_wr(
        input logic [IDX_W-1:0] idx,
        input logic [PHI_W-1:0] phi,
        input logic [R_W-1:0]   r
    );
        logic [DATA_W-1:0] w;
        w = '0;
        w[IDX_LSB +: IDX_W] = idx;
        w[PHI_LSB +: PHI_W] = phi;
        w[R_LSB +: R_W]     = r;
        return w;
    endfunction

endpackage

// File: rtl/disk_proj_sched_if.sv
// Event control, tracklet read, datapath result and projection write bus.
// master drives events and datapath results; slave is the scheduler.
interface disk_proj_sched_if;
    import disk_proj_sched_pkg::*;

    logic              start;
    logic [CW-1:0]     nent;
    logic [2:0]        bx_in;
    logic              rd_en;
    logic [AW-1:0]     rd_add;
    logic              proj_valid;
    logic              proj_plus;
    logic              proj_minus;
    logic [PHI_W-1:0]  phiD;
    logic [R_W-1:0]    rD;
    logic              wr_en_c;
    logic              wr_en_p;
    logic              wr_en_m;
    logic [AW-1:0]     wr_add_c;
    logic [AW-1:0]     wr_add_p;
    logic [AW-1:0]     wr_add_m;
    logic [DATA_W-1:0] wr_data;
    logic              done;
    logic [2:0]        bx_out;
    logic [CW-1:0]     nproj_c;
    logic [CW-1:0]     nproj_p;
    logic [CW-1:0]     nproj_m;
    logic              ovf;

    modport master (
        output start, nent, bx_in,
        output proj_valid, proj_plus, proj_minus, phiD, rD,
        input  rd_en, rd_add,
        input  wr_en_c, wr_en_p, wr_en_m,
        input  wr_add_c, wr_add_p, wr_add_m, wr_data,
        input  done, bx_out, nproj_c, nproj_p, nproj_m, ovf
    );

    modport slave (
        input  start, nent, bx_in,
        input  proj_valid, proj_plus, proj_minus, phiD, rD,
        output rd_en, rd_add,
        output wr_en_c, wr_en_p, wr_en_m,
        output wr_add_c, wr_add_p, wr_add_m, wr_data,
        output done, bx_out, nproj_c, nproj_p, nproj_m, ovf
    );

endinterface

// File: rtl/disk_proj_sched_wr_counter.sv
// Saturating projection-memory write counter with sticky overflow.
// Emits a registered write strobe and address for each accepted hit.
module proj_wr_counter
    import disk_proj_sched_pkg::*;
#(
    parameter int LIMIT = NMAX
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clr_i,
    input  logic          hit_i,
    output logic          wr_en_o,
    output logic [AW-1:0] wr_add_o,
    output logic [CW-1:0] cnt_o,
    output logic          ovf_o
);

    logic [CW-1:0] cnt_q, cnt_d;
    logic [AW-1:0] add_q, add_d;
    logic          wr_q, wr_d;
    logic          ovf_q, ovf_d;

    always_comb begin
        cnt_d = cnt_q;
        add_d = add_q;
        wr_d  = 1'b0;
        ovf_d = ovf_q;
        if (clr_i) begin
            cnt_d = '0;
            add_d = '0;
            ovf_d = 1'b0;
        end else if (hit_i) begin
            if (cnt_q >= CW'(LIMIT)) begin
                ovf_d = 1'b1;
            end else begin
                wr_d  = 1'b1;
                add_d = cnt_q[AW-1:0];
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
            add_q <= '0;
            wr_q  <= 1'b0;
            ovf_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            add_q <= add_d;
            wr_q  <= wr_d;
            ovf_q <= ovf_d;
        end
    end

    assign wr_en_o  = wr_q;
    assign wr_add_o = add_q;
    assign cnt_o    = cnt_q;
    assign ovf_o    = ovf_q;

endmodule

// File: rtl/pipe_delay.sv
// Fixed-depth register delay line with synchronous flush.
// Flush zeroes every stage so any valid bit carried in the data dies.
module pipe_delay #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] pipe_q [DEPTH];

    always_ff @(posedge clk) begin
        if (reset || clr_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                pipe_q[i] <= '0;
            end
        end else begin
            pipe_q[0] <= d_i;
            for (int i = 1; i < DEPTH; i++) begin
                pipe_q[i] <= pipe_q[i-1];
            end
        end
    end

    assign q_o = pipe_q[DEPTH-1];

endmodule

// File: rtl/disk_proj_sched.sv
// Per-event scheduler: issues tracklet reads, tracks them through the
// projection datapath and routes results into c/p/m projection memories.
module disk_proj_sched #(
    parameter int PROJ_LAT = 17,
    parameter int RD_LAT   = 2,
    parameter int NMAX     = disk_proj_sched_pkg::NMAX
) (
    input  logic             clk,
    input  logic             reset,
    disk_proj_sched_if.slave bus
);

    import disk_proj_sched_pkg::state_e, disk_proj_sched_pkg::IDLE,
           disk_proj_sched_pkg::ISSUE, disk_proj_sched_pkg::DRAIN,
           disk_proj_sched_pkg::FIN, disk_proj_sched_pkg::AW,
           disk_proj_sched_pkg::CW, disk_proj_sched_pkg::pack_wr;

    localparam int DEPTH = RD_LAT + PROJ_LAT;

    state_e        state_q, state_d;
    logic [CW-1:0] nent_q, nent_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW-1:0] infl_q, infl_d;
    logic [2:0]    bx_q, bx_d;
    logic [31:0]   data_q, data_d;

    logic [AW:0]   tail;
    logic          tail_v;
    logic [AW-1:0] tail_idx;
    logic          issue;
    logic          hit_c, hit_p, hit_m, hit_any;
    logic          ovf_c, ovf_p, ovf_m;

    assign issue    = (state_q == ISSUE);
    assign tail_v   = tail[AW];
    assign tail_idx = tail[AW-1:0];

    // Tail lines up with the datapath result of the read issued DEPTH ago.
    pipe_delay #(
        .WIDTH (AW + 1),
        .DEPTH (DEPTH)
    ) u_inflight (
        .clk   (clk),
        .reset (reset),
        .clr_i (bus.start),
        .d_i   ({issue, cnt_q[AW-1:0]}),
        .q_o   (tail)
    );

    always_comb begin
        state_d = state_q;
        nent_d  = nent_q;
        cnt_d   = cnt_q;
        bx_d    = bx_q;
        infl_d  = infl_q + CW'(issue) - CW'(tail_v);
        unique case (state_q)
            IDLE: ;
            ISSUE: begin
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == nent_q - CW'(1)) state_d = DRAIN;
            end
            DRAIN: begin
                if (infl_q == CW'(tail_v)) state_d = FIN;
            end
            FIN: state_d = IDLE;
        endcase
        // A start in any state restarts the event from scratch.
        if (bus.start) begin
            nent_d  = bus.nent;
            bx_d    = bus.bx_in;
            cnt_d   = '0;
            infl_d  = '0;
            state_d = (bus.nent == '0) ? FIN : ISSUE;
        end
    end

    assign hit_c   = tail_v & bus.proj_valid & ~bus.start;
    assign hit_p   = tail_v & bus.proj_plus  & ~bus.start;
    assign hit_m   = tail_v & bus.proj_minus & ~bus.start;
    assign hit_any = hit_c | hit_p | hit_m;
    assign data_d  = hit_any ? pack_wr(tail_idx, bus.phiD, bus.rD)
                             : data_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            nent_q  <= '0;
            cnt_q   <= '0;
            infl_q  <= '0;
            bx_q    <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            nent_q  <= nent_d;
            cnt_q   <= cnt_d;
            infl_q  <= infl_d;
            bx_q    <= bx_d;
            data_q  <= data_d;
        end
    end

    proj_wr_counter #(.LIMIT(NMAX)) u_cnt_c (
        .clk      (clk),
        .reset    (reset),
        .clr_i    (bus.start),
        .hit_i    (hit_c),
        .wr_en_o  (bus.wr_en_c),
        .wr_add_o (bus.wr_add_c),
        .cnt_o    (bus.nproj_c),
        .ovf_o    (ovf_c)
    );

    proj_wr_counter #(.LIMIT(NMAX)) u_cnt_p (
        .clk      (clk),
        .reset    (reset),
        .clr_i    (bus.start),
        .hit_i    (hit_p),
        .wr_en_o  (bus.wr_en_p),
        .wr_add_o (bus.wr_add_p),
        .cnt_o    (bus.nproj_p),
        .ovf_o    (ovf_p)
    );

    proj_wr_counter #(.LIMIT(NMAX)) u_cnt_m (
        .clk      (clk),
        .reset    (reset),
        .clr_i    (bus.start),
        .hit_i    (hit_m),
        .wr_en_o  (bus.wr_en_m),
        .wr_add_o (bus.wr_add_m),
        .cnt_o    (bus.nproj_m),
        .ovf_o    (ovf_m)
    );

    assign bus.rd_en   = issue;
    assign bus.rd_add  = cnt_q[AW-1:0];
    assign bus.done    = (state_q == FIN) & ~bus.start;
    assign bus.bx_out  = bx_q;
    assign bus.wr_data = data_q;
    assign bus.ovf     = ovf_c | ovf_p | ovf_m;

endmodule

// File: tb/tb_disk_proj_sched.sv
// Directed bench for disk_proj_sched with a fixed-latency datapath model.
// Built with NMAX=63 so the saturation case fits in one 64-entry event.
module tb_disk_proj_sched;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    disk_proj_sched_if bus();

    disk_proj_sched #(
        .PROJ_LAT (17),
        .RD_LAT   (2),
        .NMAX     (63)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int total = 0;
    int bad = 0;
    int cyc = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [13:0] phi_of(input logic [5:0] i);
        return 14'(i * 37 + 11);
    endfunction

    function automatic logic [11:0] r_of(input logic [5:0] i);
        return 12'(i * 5 + 3);
    endfunction

    // Datapath model: result for a read appears 19 cycles after the read.
    logic [6:0] hist [19];
    logic [2:0] tab [64];
    logic [6:0] tl;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 19; i++) hist[i] <= '0;
        end else begin
            hist[0] <= {bus.rd_en, bus.rd_add};
            for (int i = 1; i < 19; i++) hist[i] <= hist[i-1];
        end
    end

    assign tl = hist[18];

    always_comb begin
        bus.proj_valid = 1'b1;
        bus.proj_plus  = 1'b1;
        bus.proj_minus = 1'b1;
        bus.phiD = '0;
        bus.rD = '0;
        if (tl[6]) begin
            {bus.proj_valid, bus.proj_plus, bus.proj_minus} = tab[tl[5:0]];
            bus.phiD = phi_of(tl[5:0]);
            bus.rD = r_of(tl[5:0]);
        end
    end

    // Monitor
    int wc, wp, wm, rdn, done_n, done_cyc;
    logic [31:0] d_nc, d_np, d_nm, d_bx, d_ovf;
    logic [5:0] idx_c [64];
    logic [5:0] idx_p [64];
    logic [5:0] idx_m [64];

    function automatic logic [31:0] exp_data(input logic [5:0] i);
        return {i, phi_of(i), r_of(i)};
    endfunction

    always @(negedge clk) begin
        if (!reset) begin
            if (bus.rd_en) begin
                chk("rd_add", 32'(bus.rd_add), rdn);
                rdn++;
            end
            if (bus.wr_en_c) begin
                chk("wr_add_c", 32'(bus.wr_add_c), wc);
                chk("wr_data_c", bus.wr_data, exp_data(bus.wr_data[31:26]));
                if (wc < 64) idx_c[wc] = bus.wr_data[31:26];
                wc++;
            end
            if (bus.wr_en_p) begin
                chk("wr_add_p", 32'(bus.wr_add_p), wp);
                chk("wr_data_p", bus.wr_data, exp_data(bus.wr_data[31:26]));
                if (wp < 64) idx_p[wp] = bus.wr_data[31:26];
                wp++;
            end
            if (bus.wr_en_m) begin
                chk("wr_add_m", 32'(bus.wr_add_m), wm);
                chk("wr_data_m", bus.wr_data, exp_data(bus.wr_data[31:26]));
                if (wm < 64) idx_m[wm] = bus.wr_data[31:26];
                wm++;
            end
            if (bus.done) begin
                done_n++;
                done_cyc = cyc;
                d_nc = 32'(bus.nproj_c);
                d_np = 32'(bus.nproj_p);
                d_nm = 32'(bus.nproj_m);
                d_bx = 32'(bus.bx_out);
                d_ovf = 32'(bus.ovf);
            end
        end
    end

    task automatic clr_mon();
        wc = 0;
        wp = 0;
        wm = 0;
        rdn = 0;
        done_n = 0;
        done_cyc = 0;
    endtask

    task automatic start_ev(input int n, input int bx, output int s);
        @(negedge clk);
        bus.nent = 7'(n);
        bus.bx_in = 3'(bx);
        bus.start = 1'b1;
        s = cyc;
        @(posedge clk);
        clr_mon();
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic wait_done(input int lim);
        for (int i = 0; i < lim; i++) begin
            @(posedge clk);
            if (done_n != 0) break;
        end
        repeat (4) @(negedge clk);
    endtask

    task automatic ev_check(input int s, input int lat, input int nrd,
                            input int nc, input int np, input int nm,
                            input int bx, input int ovf);
        chk("done_count", done_n, 1);
        chk("done_latency", done_cyc - s, lat);
        chk("rd_count", rdn, nrd);
        chk("writes_c", wc, nc);
        chk("writes_p", wp, np);
        chk("writes_m", wm, nm);
        chk("nproj_c", d_nc, nc);
        chk("nproj_p", d_np, np);
        chk("nproj_m", d_nm, nm);
        chk("bx_out", d_bx, bx);
        chk("ovf", d_ovf, ovf);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int s;
        bus.start = 1'b0;
        bus.nent = '0;
        bus.bx_in = '0;
        for (int i = 0; i < 64; i++) tab[i] = 3'b100;
        clr_mon();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_rd_en", 32'(bus.rd_en), 0);
        chk("rst_rd_add", 32'(bus.rd_add), 0);
        chk("rst_wr_en", 32'({bus.wr_en_c, bus.wr_en_p, bus.wr_en_m}), 0);
        chk("rst_wr_add", 32'({bus.wr_add_c, bus.wr_add_p, bus.wr_add_m}), 0);
        chk("rst_done", 32'(bus.done), 0);
        chk("rst_nproj", 32'({bus.nproj_c, bus.nproj_p, bus.nproj_m}), 0);
        chk("rst_bx_out", 32'(bus.bx_out), 0);
        chk("rst_ovf", 32'(bus.ovf), 0);
        reset = 1'b0;

        // five entries, all central
        start_ev(5, 3, s);
        wait_done(60);
        ev_check(s, 25, 5, 5, 0, 0, 3, 0);
        for (int i = 0; i < 5; i++) chk("idx_c", 32'(idx_c[i]), i);

        // empty event
        start_ev(0, 6, s);
        wait_done(10);
        ev_check(s, 1, 0, 0, 0, 0, 6, 0);

        // c, p, m, none
        tab[0] = 3'b100;
        tab[1] = 3'b010;
        tab[2] = 3'b001;
        tab[3] = 3'b000;
        start_ev(4, 1, s);
        wait_done(60);
        ev_check(s, 24, 4, 1, 1, 1, 1, 0);
        chk("idx_c0", 32'(idx_c[0]), 0);
        chk("idx_p0", 32'(idx_p[0]), 1);
        chk("idx_m0", 32'(idx_m[0]), 2);
        for (int i = 0; i < 4; i++) tab[i] = 3'b100;

        // saturation at NMAX=63
        start_ev(64, 7, s);
        wait_done(150);
        ev_check(s, 84, 64, 63, 0, 0, 7, 1);
        chk("idx_c62", 32'(idx_c[62]), 62);

        // abort: restart 8 cycles in with nent=2, bx=5
        start_ev(10, 1, s);
        repeat (6) @(negedge clk);
        start_ev(2, 5, s);
        wait_done(60);
        ev_check(s, 22, 2, 2, 0, 0, 5, 0);
        chk("abort_idx_c0", 32'(idx_c[0]), 0);
        chk("abort_idx_c1", 32'(idx_c[1]), 1);

        // reset mid-event at cycle 6
        start_ev(10, 4, s);
        repeat (5) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("mid_rst_rd_en", 32'(bus.rd_en), 0);
        chk("mid_rst_done", 32'(bus.done), 0);
        chk("mid_rst_nproj_c", 32'(bus.nproj_c), 0);
        chk("mid_rst_bx_out", 32'(bus.bx_out), 0);
        chk("mid_rst_wr_en", 32'({bus.wr_en_c, bus.wr_en_p, bus.wr_en_m}), 0);
        reset = 1'b0;
        repeat (40) @(negedge clk);
        chk("post_rst_done", done_n, 0);
        chk("post_rst_writes", wc + wp + wm, 0);
        start_ev(1, 2, s);
        wait_done(40);
        ev_check(s, 21, 1, 1, 0, 0, 2, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/disk_proj_sched.md
DISK_PROJ_SCHED -- requirements
Module: disk_proj_sched

Interface
REQ-001 Parameters SHALL be: PROJ_LAT, default 17, fixed cycles from tracklet operands at the disk-projection datapath input to its phiD/rD/valid outputs.
REQ-002 Parameters SHALL be: RD_LAT, default 2, tracklet-parameter memory read latency; NMAX, default 64, entries per memory.
REQ-003 clk  in  1  single clock; all logic rising-edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 start  in  1  one-cycle pulse, begins processing of one event (BX).
REQ-006 nent  in  7  number of tracklets in input memory for this event, 0..NMAX, sampled on start.
REQ-007 bx_in  in  3  event number, sampled on start.
REQ-008 rd_en / rd_add  out  1 / 6  tracklet-parameter memory read strobe and address.
REQ-009 proj_valid, proj_plus, proj_minus  in  1 each  datapath sector flags (central, phi-plus neighbour, phi-minus neighbour).
REQ-010 phiD / rD  in  14 / 12  datapath projected phi and r.
REQ-011 wr_en_c, wr_en_p, wr_en_m  out  1 each  write strobes to central/plus/minus projection memories.
REQ-012 wr_add_c, wr_add_p, wr_add_m  out  6 each  write addresses; wr_data  out  32  {tracklet index[5:0], phiD[13:0], rD[11:0]}, shared by all three.
REQ-013 done  out  1  one-cycle pulse at event completion; bx_out  out  3  event number, valid with done.
REQ-014 nproj_c, nproj_p, nproj_m  out  7 each  projections written this event; ovf  out  1  sticky overflow flag; all valid with done.

Function
REQ-015 FSM SHALL have states IDLE, ISSUE, DRAIN, FIN.
REQ-016 IDLE->ISSUE on start with nent>0; IDLE->FIN on start with nent=0.
REQ-017 ISSUE SHALL assert rd_en every cycle with rd_add = 0,1,...,nent-1, one address per cycle, then -> DRAIN.
REQ-018 Each issue SHALL enter an in-flight shift register of depth RD_LAT+PROJ_LAT carrying {valid, index}.
REQ-019 At the shift-register tail, when valid: proj_valid, proj_plus, proj_minus SHALL each produce a write to c/p/m memories respectively at that memory's write counter, then increment it; when all three flags are low, the result SHALL be discarded.
REQ-020 Tail invalid SHALL produce no write regardless of datapath flags.
REQ-021 Write counters SHALL stop at NMAX; a qualifying result with counter=NMAX SHALL be dropped and set ovf.
REQ-022 DRAIN->FIN when shift register holds no valid entry; FIN asserts done one cycle with bx_out and counts, -> IDLE.
REQ-023 Latency: done SHALL occur exactly nent+RD_LAT+PROJ_LAT+1 cycles after start (nent>0); 1 cycle for nent=0.
REQ-024 start in ISSUE, DRAIN or FIN SHALL abort the event: shift register valids cleared, counters and ovf cleared, new nent/bx_in sampled, no done for aborted event.
REQ-025 Write counters and ovf SHALL clear on each accepted start; nproj_* equal the final counter values.
REQ-026 wr_en_* SHALL be registered; wr_add_*/wr_data valid in the same cycle as their strobe.

Reset
REQ-027 Reset SHALL force IDLE, clear shift register, counters, ovf; rd_en, wr_en_*, done SHALL be 0; all addresses, counts, bx_out 0.
REQ-028 Reset asserted mid-event SHALL discard the event without done; first start after deassertion SHALL be accepted normally.

Structure
REQ-029 A shared package SHALL hold the FSM state enum, NMAX, address width 6, and the wr_data field widths/positions.
REQ-030 One sub-module, proj_wr_counter (saturating counter + overflow), SHALL be instantiated three times.
REQ-031 The in-flight delay SHALL reuse the codebase pipe_delay block at WIDTH 7.

Verification
REQ-032 start, nent=5, bx_in=3, datapath flags all central -> rd_add 0..4, wr_add_c 0..4, indices 0..4, done at cycle 25, nproj_c=5, bx_out=3.
REQ-033 nent=0 -> done 1 cycle after start, all nproj_*=0, no rd_en, no writes.
REQ-034 nent=4, flags per entry c, p, m, none -> one write each to c/p/m at address 0, nproj_c/p/m = 1/1/1.
REQ-035 nent=64, all central, 2 extra entries forced via back-to-back event? No: nent=64 with NMAX=63 build -> 63 writes, ovf=1, nproj_c=63.
REQ-036 start nent=10, second start at cycle 8 with nent=2, bx_in=5 -> single done for bx 5, nproj_c=2, no writes from aborted entries.
REQ-037 reset pulse at cycle 6 of nent=10 event -> outputs zero, no done, subsequent start nent=1 completes normally.
